tick_period_monitor: RTL and testbench
======================================

Name: tick_period_monitor

Overview:
- Sequential checker that consumes the single-cycle `tick` produced by the upstream modulo counter. That counter asserts its output once per wrap.
- Measures the interval between ticks and declares lock after LOCK_N consecutive correct intervals.
- Flags early or missing ticks and keeps a saturating error count.
- Intended as the next SAT/induction test design: its properties (e.g. locked implies last interval == PERIOD) are provable only with induction.

Parameters:
PERIOD, 10, expected tick interval in clk cycles; legal range 2..2**CNT_W-2
CNT_W, 5, width of the interval counter
LOCK_N, 2, consecutive good intervals required to enter LOCKED; legal range 1..7
ERR_W, 4, width of the saturating error counter

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
tick  input  1  single-cycle event from upstream counter
locked  output  1  1 while in LOCKED state
err  output  1  registered single-cycle pulse on any interval violation
err_cnt  output  ERR_W  saturating count of violations
gap  output  CNT_W  cycles elapsed since last accepted tick (interval counter)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. rst dominates every other input in the same cycle.
- Reset values: state=IDLE, gap=0, good=0, err=0, err_cnt=0, locked=0.
- gap update:
  - When tick=1: gap<=1.
  - Otherwise, outside IDLE: gap<=gap+1, saturating at 2**CNT_W-1.
  - In IDLE without tick: gap holds 0.
  - On a tick cycle, gap equals the number of cycles since the previous tick.
- States:
  - IDLE: waiting for first tick. On tick -> ACQ, good<=0.
  - ACQ:
    - tick with gap==PERIOD: good<=good+1. If good+1==LOCK_N -> LOCKED, otherwise stay.
    - tick with gap<PERIOD (early): err pulse, good<=0, stay in ACQ. The early tick becomes the new reference; gap<=1.
    - no tick with gap==PERIOD (miss): err pulse, good<=0, -> IDLE, gap<=0.
  - LOCKED:
    - tick with gap==PERIOD: stay.
    - early tick: err pulse, -> ACQ, good<=0, gap<=1.
    - miss: err pulse, -> IDLE, gap<=0.
- Early and miss are mutually exclusive by construction. gap never exceeds PERIOD outside IDLE.
- Output timing:
  - locked is a registered decode of state; it rises the cycle after the qualifying tick.
  - err is registered and asserts the cycle after the violation cycle, for exactly one cycle.
- err_cnt increments by 1 per err event and saturates at 2**ERR_W-1. It is cleared only by rst.
- Reset mid-operation: rst asserted in any state returns all registers to reset values on the next edge. A tick coincident with rst is ignored.

Optional Feature:
- Macro: TICK_PERIOD_MON_STICKY_EN.
- When defined:
  - Adds output `err_sticky` (1 bit, reset 0), set on the first err event and held until rst.
  - While err_sticky=1, the ACQ->LOCKED transition is suppressed; the block never re-locks after any violation until reset.
- When undefined:
  - No err_sticky port.
  - The block re-acquires lock normally after violations.

Test Plan:
- Reset, then ticks at cycles 0,10,20 (PERIOD=10, LOCK_N=2) -> locked=1 at cycle 21; err never asserts; err_cnt=0.
- Locked, then next tick at cycle 27 instead of 30 -> err=1 at cycle 28; state ACQ; locked=0 at cycle 28; ticks at 37,47 -> locked=1 at cycle 48.
- Locked, tick omitted at cycle 30 -> miss detected at cycle 30; err=1 and locked=0 at cycle 31; gap=0; next tick returns the block to ACQ.
- 20 consecutive early ticks every 3 cycles with ERR_W=4 -> err_cnt saturates at 15 and stays there; locked stays 0.
- Locked, rst=1 coincident with a tick at cycle 30 -> all outputs at reset values at cycle 31; the tick is ignored and state is IDLE.
- With TICK_PERIOD_MON_STICKY_EN: one early tick, then correct ticks for 10 periods -> err_sticky=1 from the cycle after the violation; locked stays 0; after rst, normal locking resumes.

Source files
------------

// File: rtl/tick_period_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tick_period_monitor
//  Description : Checks the interval between single-cycle ticks from an
//                upstream modulo counter. Declares lock after LOCK_N
//                consecutive on-time intervals, flags early and missing
//                ticks with a one-cycle err pulse, and keeps a saturating
//                violation count.
//
//  Ports       : clk         - clock, all state updates on posedge
//                rst         - synchronous reset, active-high
//                tick        - single-cycle event from upstream counter
//                locked      - 1 while in LOCKED state
//                err         - registered one-cycle pulse per violation
//                err_cnt     - saturating count of violations
//                gap         - cycles since the last accepted tick
//                err_sticky  - (optional) set on first violation, held
//                              until rst
//
//  Options     : TICK_PERIOD_MON_STICKY_EN - adds err_sticky; once set, the
//                block is prevented from re-entering LOCKED until reset.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_period_monitor #(
    parameter int PERIOD = 10,
    parameter int CNT_W  = 5,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] gap
`ifdef TICK_PERIOD_MON_STICKY_EN
    ,
    output logic             err_sticky
`endif
);

    localparam logic [CNT_W-1:0] c_period  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] c_gap_max = {CNT_W{1'b1}};
    localparam logic [ERR_W-1:0] c_cnt_max = {ERR_W{1'b1}};
    localparam logic [3:0]       c_lock_n  = 4'(LOCK_N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_gap;
    logic [CNT_W-1:0] w_gap_nxt;
    logic [CNT_W-1:0] w_gap_inc;
    logic [2:0]       r_good;
    logic [2:0]       w_good_nxt;
    logic [3:0]       w_good_inc;
    logic             w_viol;
    logic             w_on_time;
    logic             w_early;
    logic             w_miss;
    logic             w_lock_block;
    logic             r_err;
    logic             r_locked;
    logic [ERR_W-1:0] r_err_cnt;

`ifdef TICK_PERIOD_MON_STICKY_EN
    logic r_err_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_viol) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky   = r_err_sticky;
    assign w_lock_block = r_err_sticky;
`else
    assign w_lock_block = 1'b0;
`endif

    // Interval classification. Outside IDLE the gap counter never passes
    // PERIOD, so "early" covers every tick that is not exactly on time and
    // can never coincide with a miss.
    assign w_on_time  = tick && (r_gap == c_period);
    assign w_early    = tick && (r_gap != c_period);
    assign w_miss     = !tick && (r_gap == c_period);
    assign w_gap_inc  = (r_gap == c_gap_max) ? r_gap : r_gap + CNT_W'(1);
    assign w_good_inc = {1'b0, r_good} + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_good_nxt  = r_good;
        w_viol      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (tick) begin
                    w_state_nxt = S_ACQ;
                    w_good_nxt  = 3'd0;
                    w_gap_nxt   = CNT_W'(1);
                end else begin
                    w_gap_nxt   = '0;
                end
            end

            S_ACQ: begin
                if (w_on_time) begin
                    w_gap_nxt = CNT_W'(1);
                    if (w_good_inc == c_lock_n) begin
                        // A blocked lock leaves the count parked below LOCK_N.
                        if (!w_lock_block) begin
                            w_state_nxt = S_LOCKED;
                            w_good_nxt  = w_good_inc[2:0];
                        end
                    end else begin
                        w_good_nxt = w_good_inc[2:0];
                    end
                end else if (w_early) begin
                    // Early tick restarts acquisition from this tick.
                    w_viol     = 1'b1;
                    w_good_nxt = 3'd0;
                    w_gap_nxt  = CNT_W'(1);
                end else if (w_miss) begin
                    w_viol      = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_good_nxt  = 3'd0;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt = w_gap_inc;
                end
            end

            S_LOCKED: begin
                if (w_on_time) begin
                    w_gap_nxt = CNT_W'(1);
                end else if (w_early) begin
                    w_viol      = 1'b1;
                    w_state_nxt = S_ACQ;
                    w_good_nxt  = 3'd0;
                    w_gap_nxt   = CNT_W'(1);
                end else if (w_miss) begin
                    w_viol      = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_good_nxt  = 3'd0;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt = w_gap_inc;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_good_nxt  = 3'd0;
                w_gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gap     <= '0;
            r_good    <= 3'd0;
            r_err     <= 1'b0;
            r_locked  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gap    <= w_gap_nxt;
            r_good   <= w_good_nxt;
            r_err    <= w_viol;
            // Decoding the next state keeps locked aligned with r_state.
            r_locked <= (w_state_nxt == S_LOCKED);
            if (w_viol && (r_err_cnt != c_cnt_max)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign locked  = r_locked;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;
    assign gap     = r_gap;

endmodule
`default_nettype wire

// File: tb/tb_tick_period_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_period_monitor
//  Description : Self-checking bench for tick_period_monitor. Each driven
//                cycle pushes the expected post-edge outputs from a
//                behavioural model into a queue; they are popped and
//                compared after the edge. Directed checks pin the key
//                timing points with constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_period_monitor;

    localparam int PERIOD  = 10;
    localparam int CNT_W   = 5;
    localparam int LOCK_N  = 2;
    localparam int ERR_W   = 4;
    localparam int GAP_MAX = (1 << CNT_W) - 1;
    localparam int CNT_MAX = (1 << ERR_W) - 1;
`ifdef TICK_PERIOD_MON_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [CNT_W-1:0] gap;
`ifdef TICK_PERIOD_MON_STICKY_EN
    logic             err_sticky;
`endif

    tick_period_monitor #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W),
        .LOCK_N (LOCK_N),
        .ERR_W  (ERR_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt),
        .gap        (gap)
`ifdef TICK_PERIOD_MON_STICKY_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int locked;
        int err;
        int cnt;
        int gap;
        int sticky;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state (0=IDLE, 1=ACQ, 2=LOCKED)
    int m_st = 0, m_gap = 0, m_good = 0, m_err = 0, m_cnt = 0;
    int m_lock = 0, m_sticky = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model(input bit t, input bit r);
        int v;
        int ns;
        if (r) begin
            m_st = 0; m_gap = 0; m_good = 0; m_err = 0; m_cnt = 0;
            m_lock = 0; m_sticky = 0;
            return;
        end
        v  = 0;
        ns = m_st;
        if (m_st == 0) begin
            if (t) begin
                ns = 1; m_good = 0; m_gap = 1;
            end else begin
                m_gap = 0;
            end
        end else if (t) begin
            if (m_gap == PERIOD) begin
                m_gap = 1;
                if (m_st == 1 && !(STICKY && m_sticky != 0)) begin
                    m_good = m_good + 1;
                    if (m_good >= LOCK_N) ns = 2;
                end
            end else begin
                v = 1; ns = 1; m_good = 0; m_gap = 1;
            end
        end else if (m_gap == PERIOD) begin
            v = 1; ns = 0; m_good = 0; m_gap = 0;
        end else if (m_gap < GAP_MAX) begin
            m_gap = m_gap + 1;
        end
        m_st  = ns;
        m_err = v;
        if (v != 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if (v != 0) m_sticky = 1;
        m_lock = (ns == 2) ? 1 : 0;
    endtask

    // Drive one cycle, predict, then compare after the edge.
    task automatic step(input bit t, input bit r);
        exp_t e;
        tick = t;
        rst  = r;
        model(t, r);
        e.locked = m_lock;
        e.err    = m_err;
        e.cnt    = m_cnt;
        e.gap    = m_gap;
        e.sticky = m_sticky;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        chk("locked", int'(locked), e.locked);
        chk("err", int'(err), e.err);
        chk("err_cnt", int'(err_cnt), e.cnt);
        chk("gap", int'(gap), e.gap);
`ifdef TICK_PERIOD_MON_STICKY_EN
        chk("err_sticky", int'(err_sticky), e.sticky);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Ticks at relative cycles 0, 10, 20: lock reached after the last one.
    task automatic lock_seq();
        step(1'b1, 1'b0);
        idle(9);
        step(1'b1, 1'b0);
        idle(9);
        step(1'b1, 1'b0);
    endtask

    initial begin
        bit t;

        // Reset
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_gap", int'(gap), 0);
        chk("rst_cnt", int'(err_cnt), 0);

        // Clean lock: ticks 0,10,20 -> locked at cycle 21
        step(1'b1, 1'b0);
        idle(9);
        chk("gap_at_10", int'(gap), 10);
        step(1'b1, 1'b0);
        chk("no_lock_c11", int'(locked), 0);
        idle(9);
        step(1'b1, 1'b0);
        chk("lock_c21", int'(locked), 1);
        chk("cnt_clean", int'(err_cnt), 0);

        // Early tick at 27 -> err and unlock at 28; relock at 48
        idle(6);
        step(1'b1, 1'b0);
        chk("early_err", int'(err), 1);
        chk("early_unlock", int'(locked), 0);
        chk("early_gap", int'(gap), 1);
        step(1'b0, 1'b0);
        chk("err_one_cycle", int'(err), 0);
        idle(8);
        step(1'b1, 1'b0);
        idle(9);
        step(1'b1, 1'b0);
        chk("relock_c48", int'(locked), 1);

        // Missing tick -> err, unlock, gap 0; next tick enters ACQ
        idle(9);
        chk("pre_miss_lock", int'(locked), 1);
        step(1'b0, 1'b0);
        chk("miss_err", int'(err), 1);
        chk("miss_unlock", int'(locked), 0);
        chk("miss_gap", int'(gap), 0);
        idle(3);
        chk("idle_gap", int'(gap), 0);
        step(1'b1, 1'b0);
        chk("reacq_gap", int'(gap), 1);

        // Early ticks every 3 cycles -> err_cnt saturates
        step(1'b0, 1'b1);
        for (int i = 0; i < 21; i++) begin
            step(1'b1, 1'b0);
            idle(2);
        end
        chk("cnt_sat", int'(err_cnt), CNT_MAX);
        chk("sat_unlocked", int'(locked), 0);

        // Drop to IDLE by miss, relock with saturated count, reset on a tick
        idle(12);
        lock_seq();
        chk("sat_hold", int'(err_cnt), CNT_MAX);
`ifndef TICK_PERIOD_MON_STICKY_EN
        chk("lock_after_errs", int'(locked), 1);
`endif
        idle(9);
        step(1'b1, 1'b1);
        chk("rtick_locked", int'(locked), 0);
        chk("rtick_cnt", int'(err_cnt), 0);
        chk("rtick_gap", int'(gap), 0);
        idle(4);
        chk("rtick_ignored", int'(gap), 0);

`ifdef TICK_PERIOD_MON_STICKY_EN
        // One early tick, then ten correct periods: never relocks
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b0);
        chk("sticky_set", int'(err_sticky), 1);
        for (int i = 0; i < 10; i++) begin
            idle(9);
            step(1'b1, 1'b0);
        end
        chk("sticky_nolock", int'(locked), 0);
        step(1'b0, 1'b1);
        chk("sticky_clr", int'(err_sticky), 0);
        lock_seq();
        chk("sticky_relock", int'(locked), 1);
`endif

        // Randomised ticks biased toward on-time intervals
        step(1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if (m_gap == PERIOD)
                t = ($urandom_range(0, 9) < 8);
            else
                t = ($urandom_range(0, 29) == 0);
            step(t, ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
